// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: LSU-first arbitration with an IFU starvation guard,
// one outstanding transaction. Define MEM_ARB_RR_EN for round-robin arbitration instead.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_gnt_o,
  output logic                ifu_rvalid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  // load/store
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  // memory back end
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  req_t       req_q, req_d;

  logic idle;
  logic pick_lsu;
  logic gnt_ifu, gnt_lsu;
  logic resp_fire;

  // Grants are only issued from IDLE; reset also masks them in the cycle it is asserted.
  assign idle = (state_q == S_IDLE) && !rst;

`ifdef MEM_ARB_RR_EN
  logic last_lsu_q, last_lsu_d;

  // On contention the side that was not granted last goes first.
  assign pick_lsu = lsu_req_i && (!ifu_req_i || !last_lsu_q);

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (gnt_lsu)      last_lsu_d = 1'b1;
    else if (gnt_ifu) last_lsu_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_lsu_q <= 1'b0;
    else     last_lsu_q <= last_lsu_d;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign pick_lsu = lsu_req_i && (!ifu_req_i || (starve_cnt_q != STARVE_LIM));

  // Counts LSU wins over a waiting IFU; any IFU grant or an idle IFU resets it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (idle) begin
      if (gnt_ifu || !ifu_req_i)
        starve_cnt_d = 4'd0;
      else if (gnt_lsu && (starve_cnt_q != STARVE_LIM))
        starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= 4'd0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`endif

  assign gnt_lsu = idle && pick_lsu;
  assign gnt_ifu = idle && ifu_req_i && !pick_lsu;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_lsu) begin
          owner_d     = OWN_LSU;
          req_d.we    = lsu_we_i;
          req_d.addr  = lsu_addr_i;
          req_d.wdata = lsu_wdata_i;
          req_d.wmask = lsu_wmask_i;
          state_d     = S_REQ;
        end else if (gnt_ifu) begin
          owner_d     = OWN_IFU;
          req_d.we    = 1'b0;
          req_d.addr  = ifu_addr_i;
          req_d.wdata = '0;
          req_d.wmask = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) state_d = mem_rvalid_i ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (mem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IFU;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  // A response counts only while a transaction is in flight; zero-latency completion is accepted in REQ.
  assign resp_fire = !rst &&
                     (((state_q == S_REQ) && mem_gnt_i && mem_rvalid_i) ||
                      ((state_q == S_RESP) && mem_rvalid_i));

  assign ifu_gnt_o    = gnt_ifu;
  assign lsu_gnt_o    = gnt_lsu;
  assign ifu_rvalid_o = resp_fire && (owner_q == OWN_IFU);
  assign lsu_rvalid_o = resp_fire && (owner_q == OWN_LSU);
  assign ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
  assign lsu_rdata_o  = (lsu_rvalid_o && !req_q.we) ? mem_rdata_i : '0;

  assign mem_req_o   = !rst && (state_q == S_REQ);
  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_wmask_o = req_q.wmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected values are hand-derived per vector.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt, ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req, lsu_we;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int rv_cnt;
  logic exp_lsu;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt),
    .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_wmask_i(lsu_wmask), .lsu_gnt_o(lsu_gnt),
    .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset state
    repeat (2) nxt();
    smp();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_gnt", {ifu_gnt, lsu_gnt}, 0);
    chk("rst_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
    nxt(); rst = 1'b0;

    // IFU-only read, zero-wait memory
    nxt(); ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
    smp();
    chk("t1_ifu_gnt", ifu_gnt, 1);
    chk("t1_lsu_gnt", lsu_gnt, 0);
    chk("t1_mem_req_c0", mem_req, 0);
    nxt(); ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
    smp();
    chk("t1_mem_req_c1", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_ifu_rvalid", ifu_rvalid, 1);
    chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk("t1_lsu_rvalid", lsu_rvalid, 0);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("t1_mem_req_c2", mem_req, 0);
    chk("t1_ifu_rvalid_c2", ifu_rvalid, 0);
    chk("t1_ifu_rdata_c2", ifu_rdata, 0);

    // simultaneous requests: LSU write wins, IFU follows
    nxt(); ifu_req = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    smp();
    chk("t2_lsu_gnt", lsu_gnt, 1);
    chk("t2_ifu_gnt", ifu_gnt, 0);
    nxt(); lsu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    smp();
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 32'h8000_1000);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_mem_wmask", mem_wmask, 4'hF);
    chk("t2_lsu_rvalid", lsu_rvalid, 1);
    chk("t2_lsu_rdata_wr", lsu_rdata, 0);
    chk("t2_ifu_rvalid", ifu_rvalid, 0);
    chk("t2_ifu_gnt_busy", ifu_gnt, 0);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("t2_ifu_gnt", ifu_gnt, 1);
    nxt(); ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAABB_CCDD;
    smp();
    chk("t2_ifu_mem_we", mem_we, 0);
    chk("t2_ifu_mem_wmask", mem_wmask, 0);
    chk("t2_ifu_mem_wdata", mem_wdata, 0);
    chk("t2_ifu_rvalid", ifu_rvalid, 1);
    chk("t2_ifu_rdata", ifu_rdata, 32'hAABB_CCDD);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // both held continuously: LSU x4 / IFU with the guard, strict alternation with round-robin
    for (int i = 0; i < 10; i++) begin
      nxt(); ifu_req = 1'b1; ifu_addr = 32'h8000_0100 + 32'(i) * 4;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_3000 + 32'(i) * 4;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef MEM_ARB_RR_EN
      exp_lsu = (i % 2 == 0);
`else
      exp_lsu = !(i == 4 || i == 9);
`endif
      smp();
      chk($sformatf("t3_lsu_gnt%0d", i), lsu_gnt, exp_lsu);
      chk($sformatf("t3_ifu_gnt%0d", i), ifu_gnt, !exp_lsu);
      nxt(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'(i) + 32'h100;
      smp();
      chk($sformatf("t3_lsu_rv%0d", i), lsu_rvalid, exp_lsu);
      chk($sformatf("t3_ifu_rv%0d", i), ifu_rvalid, !exp_lsu);
    end
    nxt(); ifu_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // slow memory: gnt after 3 cycles, rvalid 2 cycles later; IFU waits meanwhile
    nxt(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_2000;
    smp();
    chk("t4_lsu_gnt", lsu_gnt, 1);
    nxt(); lsu_req = 1'b0; ifu_req = 1'b1; ifu_addr = 32'h8000_0010;
    rv_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("t4_wait_req%0d", k), mem_req, 1);
      chk($sformatf("t4_wait_addr%0d", k), mem_addr, 32'h8000_2000);
      chk($sformatf("t4_wait_gnt%0d", k), {ifu_gnt, lsu_gnt}, 0);
      rv_cnt += int'(lsu_rvalid) + int'(ifu_rvalid);
      nxt();
    end
    mem_gnt = 1'b1;
    smp();
    chk("t4_gnt_req", mem_req, 1);
    chk("t4_gnt_addr", mem_addr, 32'h8000_2000);
    chk("t4_gnt_nogrant", {ifu_gnt, lsu_gnt}, 0);
    rv_cnt += int'(lsu_rvalid) + int'(ifu_rvalid);
    nxt(); mem_gnt = 1'b0;
    smp();
    chk("t4_resp_req", mem_req, 0);
    chk("t4_resp_nogrant", {ifu_gnt, lsu_gnt}, 0);
    rv_cnt += int'(lsu_rvalid) + int'(ifu_rvalid);
    nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    smp();
    chk("t4_lsu_rvalid", lsu_rvalid, 1);
    chk("t4_lsu_rdata", lsu_rdata, 32'hCAFE_F00D);
    chk("t4_ifu_rvalid", ifu_rvalid, 0);
    chk("t4_ifu_gnt_resp", ifu_gnt, 0);
    rv_cnt += int'(lsu_rvalid) + int'(ifu_rvalid);
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    rv_cnt += int'(lsu_rvalid) + int'(ifu_rvalid);
    chk("t4_rv_pulses", rv_cnt, 1);
    chk("t4_ifu_gnt_after", ifu_gnt, 1);
    nxt(); ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    smp();
    chk("t4_ifu_rvalid", ifu_rvalid, 1);
    chk("t4_ifu_addr", mem_addr, 32'h8000_0010);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset while in RESP, stale rvalid afterwards
    nxt(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_4000;
    smp();
    chk("t5_lsu_gnt", lsu_gnt, 1);
    nxt(); lsu_req = 1'b0; mem_gnt = 1'b1;
    smp();
    chk("t5_mem_req", mem_req, 1);
    nxt(); mem_gnt = 1'b0; rst = 1'b1;
    smp();
    chk("t5_rst_rvalid", lsu_rvalid, 0);
    nxt(); rst = 1'b0;
    smp();
    chk("t5_idle_req", mem_req, 0);
    chk("t5_idle_addr", mem_addr, 0);
    nxt(); mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
    smp();
    chk("t5_stale_lsu_rv", lsu_rvalid, 0);
    chk("t5_stale_ifu_rv", ifu_rvalid, 0);
    chk("t5_stale_rdata", {ifu_rdata, lsu_rdata}, 0);
    chk("t5_stale_req", mem_req, 0);

    // stray response in IDLE with nothing pending
    nxt(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    smp();
    chk("t6_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
    chk("t6_rdata", {ifu_rdata, lsu_rdata}, 0);
    chk("t6_gnt", {ifu_gnt, lsu_gnt}, 0);
    chk("t6_req", mem_req, 0);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    smp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory access port of the RV32E core between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Sits between the IFU/LSU and the memory back end (DPI-backed memory model or bus bridge).
- Arbitrates requests, holds one outstanding transaction and routes each response back to its owner.
- LSU has priority, with a starvation guard for the IFU.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive LSU grants allowed while IFU waits before IFU is forced ahead (range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_req  in  1  IFU read request; held with ifu_addr until ifu_gnt
- ifu_addr  in  ADDR_W  fetch address
- ifu_gnt  out  1  request accepted (1-cycle pulse)
- ifu_rvalid  out  1  fetch data valid (1-cycle pulse)
- ifu_rdata  out  DATA_W  fetched instruction
- lsu_req  in  1  LSU request; held with lsu_* fields until lsu_gnt
- lsu_we  in  1  1=write, 0=read
- lsu_addr  in  ADDR_W  access address
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte write mask
- lsu_gnt  out  1  request accepted (1-cycle pulse)
- lsu_rvalid  out  1  read data / write ack (1-cycle pulse)
- lsu_rdata  out  DATA_W  load data (0 for writes)
- mem_req  out  1  downstream request
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- mem_gnt  in  1  downstream accepted request
- mem_rvalid  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream response data

Behaviour:
- FSM states: IDLE, REQ, RESP. Registers: owner (IFU/LSU), latched request fields, starve_cnt (4 bits).
- Reset values: state=IDLE, starve_cnt=0, owner=IFU, all mem_* outputs 0. Reset forces IDLE from any state; an in-flight response is discarded.
- IDLE, no request: stay in IDLE; all gnt outputs 0.
- IDLE, request(s) pending: select a winner; assert its *_gnt combinationally in this same cycle; latch its fields (IFU: we=0, wmask=0, wdata=0); next state REQ.
- Selection rule:
  - Only one requester pending: that requester wins.
  - Both pending: LSU wins, unless starve_cnt==STARVE_MAX, in which case IFU wins.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_MAX, on each LSU grant while ifu_req=1.
  - starve_cnt clears on any IFU grant.
  - starve_cnt clears in any IDLE cycle with ifu_req=0.
- REQ: mem_req=1 with the latched fields, held stable until mem_gnt.
  - mem_gnt && mem_rvalid in the same cycle: zero-latency completion; deliver the response and go to IDLE.
  - mem_gnt only: go to RESP.
- RESP: mem_req=0; wait for mem_rvalid.
  - On mem_rvalid: pulse the owner's *_rvalid and drive *_rdata=mem_rdata for one cycle.
  - For a write owner, lsu_rdata=0.
  - Next state IDLE.
- Outside REQ/RESP, mem_rvalid is ignored. Non-owner rvalid is always 0.
- rdata outputs are 0 whenever the corresponding rvalid=0.
- Minimum latency, zero-wait memory: request seen in IDLE at cycle 0 -> gnt in cycle 0 -> mem_req in cycle 1 -> rvalid in cycle 1. A new grant follows in cycle 2.
- Throughput: at most one transaction per 2 cycles; exactly one outstanding transaction.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - When both requesters are pending, the winner alternates by round-robin: the requester not granted last wins.
  - starve_cnt is not implemented and STARVE_MAX is ignored.
- MEM_ARB_RR_EN undefined: fixed LSU priority with the starvation guard as described above.

Test Plan:
- IFU-only read at 0x80000000, mem_gnt=1 immediately, mem_rvalid in the same cycle with rdata=0x00000413 -> ifu_gnt in cycle 0, mem_req/addr in cycle 1, ifu_rvalid=1 with ifu_rdata=0x00000413 in cycle 1, idle in cycle 2.
- ifu_req and lsu_req both raised in cycle 0, LSU write 0xDEADBEEF to 0x80001000 with wmask=0xF -> lsu_gnt first, mem_we=1, lsu_rvalid with lsu_rdata=0; then IFU granted in the next IDLE.
- IFU and LSU held continuously requesting, STARVE_MAX=4 -> grant order LSU x4, IFU, LSU x4, IFU; with MEM_ARB_RR_EN, strict alternation.
- mem_gnt delayed 3 cycles, then mem_rvalid 2 cycles after mem_gnt -> mem_req and fields stable for 3 cycles; exactly one owner rvalid pulse; no gnt during the wait.
- rst asserted while in RESP, then a stale mem_rvalid arrives one cycle after rst deasserts -> state IDLE, no rvalid pulse, all outputs 0.
- Stray mem_rvalid while in IDLE with no request -> no rvalid outputs asserted.
